decoder_nx_scan: RTL and testbench
==================================

// Module: decoder_nx_scan
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder (SEL_W -> 2**SEL_W lines). Successor to the fixed 3-to-8 gate-level decoder.
//  Adds a clocked direct-decode path with valid/ready handshake, plus free-running and one-shot scan modes.
//  Scan modes walk the active line with a programmable dwell. Drives row/digit-select strobes, e.g. LED/7-seg multiplexing.
// PARAMETERS
//  SEL_W      3  select width; OUT_W = 2**SEL_W output lines (localparam)
//  DWELL_W    8  width of dwell-count input
//  ACTIVE_LOW 0  1: D inverted at output register (inactive lines = 1)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        synchronous reset, active low
//  en         in   1        clock enable; 0 freezes all state and outputs
//  mode       in   2        00 OFF, 01 DIRECT, 10 SCAN, 11 ONESHOT
//  sel_valid  in   1        sel presented (DIRECT only)
//  sel        in   SEL_W    line index to decode
//  sel_ready  out  1        1 when a sel can be accepted
//  dwell      in   DWELL_W  cycles-1 each line stays active in scan modes
//  D          out  OUT_W    registered one-hot output (polarity per ACTIVE_LOW)
//  idx        out  SEL_W    index of currently active line
//  wrap       out  1        1-cycle pulse when a scan step goes OUT_W-1 -> 0
//  done       out  1        1-cycle pulse at end of ONESHOT sweep
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; D all-inactive; idx=0; dwell_cnt=0; sel_ready=0; wrap=0; done=0.
//   Reset overrides en and mode.
//  en=0: no register changes; wrap/done hold their last value (normally 0); sel_ready forced 0.
//  States: IDLE, HOLD, SCAN, SHOT. Mode is sampled every enabled cycle:
//   OFF (00): ->IDLE next cycle. D all-inactive, idx=0, sel_ready=0.
//   DIRECT (01): sel_ready=1 (combinational: en & mode==01).
//    Accept on sel_valid & sel_ready. Next cycle: D=onehot(sel), idx=sel, state HOLD.
//    Latency 1. D holds until the next accept or a mode change. No accept -> D unchanged.
//   SCAN (10): on entry from any other state: idx=0, D=onehot(0), dwell_cnt=dwell.
//    Each cycle dwell_cnt decrements. At dwell_cnt==0: idx=(idx+1) mod OUT_W, reload dwell_cnt=dwell
//     (dwell sampled at reload). Each line is active dwell+1 cycles; dwell=0 advances every cycle.
//    wrap=1 on the cycle D becomes onehot(0) through wrap-around (not on entry).
//   ONESHOT (11): as SCAN, but at the would-be wrap point it goes to IDLE instead.
//    D all-inactive, done=1 for that one cycle, idx=0.
//    Stays IDLE while mode remains 11; re-arm by leaving and re-entering 11.
//  Mode change mid-step: takes effect on the next enabled edge. Partial dwell is discarded; no wrap/done is generated.
//  Exactly one D line is active, or none in IDLE. Never two, including across mode switches.
//  All outputs registered except sel_ready. idx always equals the encoded position of the active D line (0 when none).
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with mode=10, en=1 -> D=8'h00, idx=0, wrap=0, done=0, sel_ready=0.
//  2 DIRECT: mode=01; sel=5, valid 1 cycle -> next cycle D=8'h20, idx=5. Hold 10 cycles unchanged.
//    Then sel=0 -> D=8'h01.
//  3 SCAN dwell=2: D sequence 01,01,01,02,02,02,...,80,80,80,01.
//    wrap=1 only on the first 01 after 80. Period 24 cycles.
//  4 ONESHOT dwell=0: D=01,02,...,80, then 00 with done=1 for 1 cycle.
//    Stays 00 while mode=11; mode 00->11 restarts at 01.
//  5 en=0 for 5 cycles mid-SCAN (D=08, dwell_cnt=1) -> D, idx frozen, sel_ready=0.
//    Resumes with 1 remaining cycle before D=10.
//  6 Sync reset mid-SCAN at D=40 -> D=00 next edge. Release with mode=10 -> D=01 restarts at idx 0.
//    Repeat with SEL_W=4, ACTIVE_LOW=1: D=16'hFFFE at scan start.

Source files
------------

// File: rtl/decoder_nx_scan.sv
// -----------------------------------------------------------------------------
// decoder_nx_scan
//   Registered binary-to-one-hot decoder (SEL_W -> 2**SEL_W lines) with a
//   direct-decode path (valid/ready) and free-running / one-shot scan modes
//   that walk the active line with a programmable dwell. Intended for
//   row/digit-select strobes such as LED or 7-segment multiplexing.
//
// Parameters
//   SEL_W      select width, OUT_W = 2**SEL_W output lines
//   DWELL_W    width of the dwell input
//   ACTIVE_LOW 1: active line driven 0, inactive lines driven 1
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low (overrides en and mode)
//   en         clock enable; 0 freezes all state and outputs
//   mode       00 OFF, 01 DIRECT, 10 SCAN, 11 ONESHOT
//   sel_valid  sel presented (DIRECT only)
//   sel        line index to decode
//   sel_ready  combinational: a sel can be accepted this cycle
//   dwell      cycles-1 each line stays active in the scan modes
//   D          registered one-hot line drive (polarity per ACTIVE_LOW)
//   idx        index of the active line (0 when none is active)
//   wrap       1-cycle pulse when a scan step goes OUT_W-1 -> 0
//   done       1-cycle pulse at the end of a one-shot sweep
// -----------------------------------------------------------------------------
module decoder_nx_scan #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] D,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap,
  output logic                  done
);

  localparam int OUT_W = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN, SHOT} state_t;
  typedef enum logic [1:0] {
    M_OFF     = 2'b00,
    M_DIRECT  = 2'b01,
    M_SCAN    = 2'b10,
    M_ONESHOT = 2'b11
  } mode_t;

  // Drive pattern with no line active, in output polarity.
  localparam logic [OUT_W-1:0] D_NONE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  // One-hot drive for line i, already in output polarity so the inversion
  // lives inside the output register rather than after it.
  function automatic logic [OUT_W-1:0] line_drive(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  state_t             state;
  logic [DWELL_W-1:0] dwell_cnt;
  // Set when a one-shot sweep has finished; blocks re-arming until mode
  // leaves ONESHOT at least once.
  logic               shot_spent;

  logic last_line;
  assign last_line = (idx == {SEL_W{1'b1}});

  assign sel_ready = rst_n & en & (mode == M_DIRECT);

  // NOTE: all state is updated with non-blocking assignments in a single
  // clocked block; the reset is sampled on the clock edge (synchronous), so
  // every register, including the pulses, gets an explicit reset value here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      D          <= D_NONE;
      idx        <= '0;
      dwell_cnt  <= '0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      shot_spent <= 1'b0;
    end else if (en) begin
      // Pulses default low on every enabled cycle; they hold while en=0.
      wrap <= 1'b0;
      done <= 1'b0;

      unique case (mode_t'(mode))
        M_OFF: begin
          state      <= IDLE;
          D          <= D_NONE;
          idx        <= '0;
          shot_spent <= 1'b0;
        end

        M_DIRECT: begin
          // Without an accept the current drive is kept as-is, which also
          // keeps idx consistent with D when arriving from a scan mode.
          state      <= HOLD;
          shot_spent <= 1'b0;
          if (sel_valid) begin
            D   <= line_drive(sel);
            idx <= sel;
          end
        end

        M_SCAN: begin
          shot_spent <= 1'b0;
          if (state != SCAN) begin
            // Entry from any other state restarts at line 0; a partial
            // dwell from a previous mode is discarded.
            state     <= SCAN;
            idx       <= '0;
            D         <= line_drive('0);
            dwell_cnt <= dwell;
          end else if (dwell_cnt == '0) begin
            idx       <= idx + SEL_W'(1);
            D         <= line_drive(idx + SEL_W'(1));
            dwell_cnt <= dwell;
            wrap      <= last_line;
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end

        M_ONESHOT: begin
          if (state != SHOT) begin
            if (!shot_spent) begin
              state     <= SHOT;
              idx       <= '0;
              D         <= line_drive('0);
              dwell_cnt <= dwell;
            end
          end else if (dwell_cnt == '0) begin
            dwell_cnt <= dwell;
            if (last_line) begin
              // End of sweep: go dark instead of wrapping.
              state      <= IDLE;
              D          <= D_NONE;
              idx        <= '0;
              done       <= 1'b1;
              shot_spent <= 1'b1;
            end else begin
              idx <= idx + SEL_W'(1);
              D   <= line_drive(idx + SEL_W'(1));
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_nx_scan.sv
module tb_decoder_nx_scan;

  logic        clk = 1'b0;
  logic        rst_n, en, sel_valid;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic [7:0]  dwell;
  logic        sel_ready, wrap, done;
  logic [7:0]  d;
  logic [2:0]  idx;

  // Second instance: 16 lines, active-low drive.
  logic [3:0]  sel2;
  logic        sel_ready2, wrap2, done2;
  logic [15:0] d2;
  logic [3:0]  idx2;

  assign sel2 = {1'b0, sel};

  always #5 clk = ~clk;

  decoder_nx_scan #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .sel_ready(sel_ready), .dwell(dwell), .D(d), .idx(idx),
    .wrap(wrap), .done(done)
  );

  decoder_nx_scan #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel2), .sel_ready(sel_ready2), .dwell(dwell), .D(d2), .idx(idx2),
    .wrap(wrap2), .done(done2)
  );

  typedef struct {
    string      nm;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       sv;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic [7:0] d;
    logic [2:0] idx;
    logic       wrap;
    logic       done;
    logic       ready;
  } vec_t;

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [2:0] idx;
    logic       wrap;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic r, input logic e,
                              input logic [1:0] m, input logic sv, input logic [2:0] s,
                              input logic [7:0] dw, input logic [7:0] xd,
                              input logic [2:0] xi, input logic xw, input logic xdn,
                              input logic xr);
    vec_t v;
    v.nm = nm; v.rst_n = r; v.en = e; v.mode = m; v.sv = sv; v.sel = s;
    v.dwell = dw; v.d = xd; v.idx = xi; v.wrap = xw; v.done = xdn; v.ready = xr;
    return v;
  endfunction

  // Drive one cycle of stimulus, check the combinational ready, queue the
  // expected registered outputs, then pop and compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    rst_n = v.rst_n; en = v.en; mode = v.mode;
    sel_valid = v.sv; sel = v.sel; dwell = v.dwell;
    #1;
    check({v.nm, ".ready"}, 16'(sel_ready), 16'(v.ready));
    exp_q.push_back('{nm: v.nm, d: v.d, idx: v.idx, wrap: v.wrap, done: v.done});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      check({e.nm, ".D"},    16'(d),    16'(e.d));
      check({e.nm, ".idx"},  16'(idx),  16'(e.idx));
      check({e.nm, ".wrap"}, 16'(wrap), 16'(e.wrap));
      check({e.nm, ".done"}, 16'(done), 16'(e.done));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    int   line;

    //          name        rst en mode  sv sel dwell  D      idx w  dn rdy
    tbl[0] = mk("reset0",   0,  1, 2'b10, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0);
    tbl[1] = mk("reset1",   0,  1, 2'b10, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0);
    tbl[2] = mk("dir_sel5", 1,  1, 2'b01, 1, 5, 8'd0, 8'h20, 5, 0, 0, 1);
    tbl[3] = mk("dir_sel0", 1,  1, 2'b01, 1, 0, 8'd0, 8'h01, 0, 0, 0, 1);
    tbl[4] = mk("dir_en0",  1,  0, 2'b01, 1, 3, 8'd0, 8'h01, 0, 0, 0, 0);
    tbl[5] = mk("dir_sel7", 1,  1, 2'b01, 1, 7, 8'd0, 8'h80, 7, 0, 0, 1);
    tbl[6] = mk("dir_noacc",1,  1, 2'b01, 0, 2, 8'd0, 8'h80, 7, 0, 0, 1);
    tbl[7] = mk("off",      1,  1, 2'b00, 1, 4, 8'd0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) apply(tbl[i]);
    // Direct hold: 10 cycles with no valid, D stays on line 5.
    for (int i = 0; i < 10; i++)
      apply(mk("dir_hold", 1, 1, 2'b01, 0, 2, 8'd0, 8'h20, 5, 0, 0, 1));
    for (int i = 3; i < 8; i++) apply(tbl[i]);

    // Free-running scan, dwell=2: 3 cycles per line, wrap on first 01 after 80.
    for (int k = 0; k <= 24; k++) begin
      line = (k / 3) % 8;
      apply(mk("scan", 1, 1, 2'b10, 0, 0, 8'd2, 8'(1 << line), 3'(line), k == 24, 0, 0));
    end

    // Freeze mid-scan at D=08 with one dwell count left.
    apply(mk("off2", 1, 1, 2'b00, 0, 0, 8'd2, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k <= 10; k++) begin
      line = k / 3;
      apply(mk("scan_pre", 1, 1, 2'b10, 0, 0, 8'd2, 8'(1 << line), 3'(line), 0, 0, 0));
    end
    for (int i = 0; i < 5; i++)
      apply(mk("freeze", 1, 0, 2'b01, 1, 6, 8'd2, 8'h08, 3, 0, 0, 0));
    apply(mk("resume0", 1, 1, 2'b10, 0, 0, 8'd2, 8'h08, 3, 0, 0, 0));
    apply(mk("resume1", 1, 1, 2'b10, 0, 0, 8'd2, 8'h10, 4, 0, 0, 0));

    // One-shot sweep, dwell=0.
    apply(mk("off3", 1, 1, 2'b00, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      apply(mk("shot", 1, 1, 2'b11, 0, 0, 8'd0, 8'(1 << k), 3'(k), 0, 0, 0));
    apply(mk("shot_done", 1, 1, 2'b11, 0, 0, 8'd0, 8'h00, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      apply(mk("shot_idle", 1, 1, 2'b11, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0));
    apply(mk("shot_off",    1, 1, 2'b00, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0));
    apply(mk("shot_rearm0", 1, 1, 2'b11, 0, 0, 8'd0, 8'h01, 0, 0, 0, 0));
    apply(mk("shot_rearm1", 1, 1, 2'b11, 0, 0, 8'd0, 8'h02, 1, 0, 0, 0));

    // Synchronous reset mid-scan at D=40, both instances.
    apply(mk("off4", 1, 1, 2'b00, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++)
      apply(mk("scan_r", 1, 1, 2'b10, 0, 0, 8'd0, 8'(1 << k), 3'(k), 0, 0, 0));
    apply(mk("rst_mid", 0, 1, 2'b10, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0));
    check("rst_mid.D16",   d2,         16'hFFFF);
    check("rst_mid.idx16", 16'(idx2),  16'h0000);
    apply(mk("rst_rel0", 1, 1, 2'b10, 0, 0, 8'd0, 8'h01, 0, 0, 0, 0));
    check("rst_rel0.D16",  d2,         16'hFFFE);
    check("rst_rel0.idx16",16'(idx2),  16'h0000);
    apply(mk("rst_rel1", 1, 1, 2'b10, 0, 0, 8'd0, 8'h02, 1, 0, 0, 0));
    check("rst_rel1.D16",  d2,         16'hFFFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
